// File: rtl/whack_pkg.sv
// Shared constants and state encodings for the PC-link command decoder:
// the ASCII command set, the one-byte reply codes, and the state
// encodings for the decoder FSM and the reply-slot handshake.
package whack_pkg;

    // Command bytes accepted from the PC
    localparam logic [7:0] CMD_START  = 8'h53; // 'S'
    localparam logic [7:0] CMD_HIT    = 8'h48; // 'H'
    localparam logic [7:0] CMD_PING   = 8'h50; // 'P'
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30; // '0'

    // Reply bytes sent back to the PC
    localparam logic [7:0] RPL_START  = 8'h4B; // 'K'
    localparam logic [7:0] RPL_HIT    = 8'h41; // 'A'
    localparam logic [7:0] RPL_MISS   = 8'h4E; // 'N'
    localparam logic [7:0] RPL_ERR    = 8'h3F; // '?'
    localparam logic [7:0] RPL_PING   = 8'h50; // 'P'

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ARG = 1'b1
    } dec_state_t;

    // Reply-slot transmit handshake:
    // READY -> (tx_start) GUARD -> WAIT_HI -> (busy seen) WAIT_LO -> (busy gone) READY
    typedef enum logic [1:0] {
        SL_READY   = 2'd0,
        SL_GUARD   = 2'd1,
        SL_WAIT_HI = 2'd2,
        SL_WAIT_LO = 2'd3
    } slot_state_t;

endpackage

// File: rtl/uart_resp_slot.sv
// One-entry reply buffer feeding uart_tx. A reply is held until the
// transmitter is free, then issued with a one-cycle tx_start. uart_tx
// raises busy one cycle late, so the cycle after tx_start ignores busy,
// and the next send waits for a full busy high->low cycle.
module uart_resp_slot
    import whack_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data
);

    slot_state_t st_q, st_d;
    logic        full_q, full_d;
    logic [7:0]  slot_q, slot_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        drain;

    // Next-state: drain before load so a same-cycle load refills the slot
    always_comb begin
        st_d       = st_q;
        full_d     = full_q;
        slot_d     = slot_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        drain      = full_q && (st_q == SL_READY) && !tx_busy;

        case (st_q)
            SL_GUARD:   st_d = SL_WAIT_HI;
            SL_WAIT_HI: if (tx_busy)  st_d = SL_WAIT_LO;
            SL_WAIT_LO: if (!tx_busy) st_d = SL_READY;
            default:    if (drain)    st_d = SL_GUARD;
        endcase

        if (drain) begin
            tx_start_d = 1'b1;
            tx_data_d  = slot_q;
            full_d     = 1'b0;
        end

        // A reply arriving on a full, non-draining slot is dropped
        if (load && (!full_q || drain)) begin
            slot_d = load_byte;
            full_d = 1'b1;
        end
    end

    // Slot and handshake registers
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q       <= SL_READY;
            full_q     <= 1'b0;
            slot_q     <= 8'h00;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            st_q       <= st_d;
            full_q     <= full_d;
            slot_q     <= slot_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Receive-side command parser for the PC link. Decodes 'S' (start),
// 'H'<digit> (hit on a mole index) and 'P' (ping) from the uart_rx byte
// stream and emits registered one-cycle pulses. An 'H' frame is
// abandoned if its argument byte does not arrive within TIMEOUT_MS.
// Optional build macro CMD_ACK_EN: adds a one-byte reply per decoded
// event via uart_resp_slot; without it tx_start/tx_data are tied to 0.
module uart_cmd_decoder
    import whack_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TIMEOUT_MS = 50,
    parameter int NUM_MOLES  = 5
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic [NUM_MOLES-1:0] mole_position,
    input  logic                 game_active,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 start_pulse,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 frame_error
);

    localparam int TO_LOAD = CLK_HZ / 1000 * TIMEOUT_MS - 1;
    localparam int CNT_W   = (TO_LOAD > 0) ? $clog2(TO_LOAD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TO_LOAD);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             err_q, err_d;
`ifdef CMD_ACK_EN
    logic             ping_d;
`endif

    // Argument decode: bytes below '0' wrap to large offsets and fail the range test
    logic [7:0] arg_off;
    logic       arg_ok;
    logic       mole_hit;
    assign arg_off  = rx_data - ASCII_ZERO;
    assign arg_ok   = (arg_off < 8'(NUM_MOLES));
    assign mole_hit = |(mole_position & (NUM_MOLES'(1) << arg_off));

    // Frame parser: next state, timeout counter and event pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CMD_ACK_EN
        ping_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_ready) begin
                    case (rx_data)
                        CMD_START: start_d = 1'b1;
                        CMD_HIT: begin
                            state_d = WAIT_ARG;
                            cnt_d   = CNT_LOAD;
                        end
                        CMD_PING: begin
`ifdef CMD_ACK_EN
                            ping_d = 1'b1;
`endif
                        end
                        ASCII_CR, ASCII_LF: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            default: begin
                // A byte in the expiry cycle still wins over the timeout
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                if (rx_ready) begin
                    state_d = IDLE;
                    if (arg_ok) begin
                        hit_d  = game_active && mole_hit;
                        miss_d = !(game_active && mole_hit);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    // FSM, counter and registered pulse outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign start_pulse = start_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign frame_error = err_q;

`ifdef CMD_ACK_EN
    logic       rpl_vld;
    logic [7:0] rpl_byte;

    // Reply selection; events are mutually exclusive so order is cosmetic
    always_comb begin
        rpl_vld  = start_d | hit_d | miss_d | err_d | ping_d;
        rpl_byte = 8'h00;
        if (start_d)     rpl_byte = RPL_START;
        else if (hit_d)  rpl_byte = RPL_HIT;
        else if (miss_d) rpl_byte = RPL_MISS;
        else if (err_d)  rpl_byte = RPL_ERR;
        else if (ping_d) rpl_byte = RPL_PING;
    end

    uart_resp_slot u_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (rpl_vld),
        .load_byte (rpl_byte),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );
`else
    // No reply path: outputs are constant 0; tx_busy is folded in only so
    // the port is consumed, the AND still reduces to a constant
    assign tx_start = 1'b0 & tx_busy;
    assign tx_data  = 8'h00;
`endif

endmodule
